// File: rtl/mac_pkg.sv
// mac_pkg: shared types and constants for the MAC RX AXI-Stream output stage.
package mac_pkg;
  typedef enum logic [1:0] {RX_IDLE, RX_FRAME, RX_DROP} rx_state_e;
  typedef struct packed {
    logic last;
    logic user;
  } rx_flags_t;
  // Terminating beat: zero data, byte 0 only, last with error flag.
  localparam rx_flags_t TERM_FLAGS = '{last: 1'b1, user: 1'b1};
  localparam int TERM_KEEP = 1;
endpackage

// File: rtl/mac_rx_axis_master_if.sv
// mac_rx_axis_master_if: MAC RX word input plus AXI-Stream master output bundle.
interface mac_rx_axis_master_if #(parameter int DATA_WIDTH = 32);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  logic [DATA_WIDTH-1:0] rx_data;
  logic [KEEP_WIDTH-1:0] rx_keep;
  logic rx_valid;
  logic rx_last;
  logic rx_err;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic [KEEP_WIDTH-1:0] m_axis_tkeep;
  logic m_axis_tvalid;
  logic m_axis_tlast;
  logic m_axis_tuser;
  logic m_axis_trdy;
  logic rx_overflow;
  modport master (
    input rx_data, rx_keep, rx_valid, rx_last, rx_err, m_axis_trdy,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser, rx_overflow
  );
  modport slave (
    output rx_data, rx_keep, rx_valid, rx_last, rx_err, m_axis_trdy,
    input m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser, rx_overflow
  );
endinterface

// File: rtl/mac_rx_sync_fifo.sv
// mac_rx_sync_fifo: synchronous first-word-fall-through FIFO with wrap-bit pointers.
module mac_rx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic w_wr, w_rd;
  assign full = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty = r_wr_ptr == r_rd_ptr;
  assign w_wr = wr_en && !full;
  assign w_rd = rd_en && !empty;
  // Head is forced to zero when empty so outputs read as zero out of reset.
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
endmodule

// File: rtl/mac_rx_axis_master.sv
// mac_rx_axis_master: buffers the MAC RX word stream and presents it as AXI-Stream,
// dropping frames on overflow and closing started frames with an error beat.
module mac_rx_axis_master
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input logic clk,
  input logic reset,
  mac_rx_axis_master_if.master axis
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int EW = DATA_WIDTH + KEEP_WIDTH + $bits(rx_flags_t);
  rx_state_e r_state;
  logic r_term_pending, r_overflow;
  logic w_full, w_empty, w_term, w_drop, w_wr_en;
  rx_flags_t w_rx_flags, w_out_flags;
  logic [EW-1:0] w_wr_data, w_rd_data;
  assign w_term = r_term_pending && !w_full;
  // Any incoming beat this cycle is lost: either the FIFO is full or the terminator owns the write.
  assign w_drop = w_term || w_full;
  assign w_wr_en = w_term || (axis.rx_valid && !w_full && r_state != RX_DROP);
  assign w_rx_flags = '{last: axis.rx_last, user: axis.rx_last && axis.rx_err};
  assign w_wr_data = w_term ? {DATA_WIDTH'(0), KEEP_WIDTH'(TERM_KEEP), TERM_FLAGS}
                            : {axis.rx_data, axis.rx_keep, w_rx_flags};
  mac_rx_sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr_en(w_wr_en),
    .wr_data(w_wr_data),
    .rd_en(axis.m_axis_trdy),
    .rd_data(w_rd_data),
    .full(w_full),
    .empty(w_empty)
  );
  assign {axis.m_axis_tdata, axis.m_axis_tkeep, w_out_flags} = w_rd_data;
  assign axis.m_axis_tlast = w_out_flags.last;
  assign axis.m_axis_tuser = w_out_flags.user;
  assign axis.m_axis_tvalid = !w_empty;
  assign axis.rx_overflow = r_overflow;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= RX_IDLE;
      r_term_pending <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= axis.rx_valid && w_drop && r_state != RX_DROP;
      r_term_pending <= w_term ? 1'b0 : r_term_pending || (axis.rx_valid && w_full && r_state == RX_FRAME);
      if (axis.rx_valid)
        r_state <= axis.rx_last ? RX_IDLE : (w_drop || r_state == RX_DROP) ? RX_DROP : RX_FRAME;
    end
endmodule

// File: tb/tb_mac_rx_axis_master.sv
// tb_mac_rx_axis_master: scoreboard bench for the MAC RX AXI-Stream output stage.
module tb_mac_rx_axis_master;
  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        u;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  int n_vec = 0;
  int n_err = 0;
  int ovf_cnt = 0;
  int base;
  exp_t q[$];
  mac_rx_axis_master_if #(.DATA_WIDTH(32)) bus ();
  mac_rx_axis_master #(.DATA_WIDTH(32), .FIFO_DEPTH(16)) dut (
    .clk(clk),
    .reset(reset),
    .axis(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (bus.rx_overflow === 1'b1) ovf_cnt++;
    if (bus.m_axis_tvalid && bus.m_axis_trdy) begin
      if (q.size() == 0) chk("sb_empty", q.size(), 1);
      else begin
        e = q.pop_front();
        chk("tdata", bus.m_axis_tdata, e.d);
        chk("tkeep", bus.m_axis_tkeep, e.k);
        chk("tlast", bus.m_axis_tlast, e.l);
        chk("tuser", bus.m_axis_tuser, e.u);
      end
    end
  end
  task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic e, input bit push);
    bus.rx_data = d;
    bus.rx_keep = k;
    bus.rx_last = l;
    bus.rx_err = e;
    bus.rx_valid = 1'b1;
    if (push) q.push_back('{d: d, k: k, l: l, u: l & e});
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    bus.rx_last = 1'b0;
    bus.rx_err = 1'b0;
  endtask
  task automatic drain(input string tag);
    bus.m_axis_trdy = 1'b1;
    for (int i = 0; i < 100 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk(tag, q.size(), 0);
    @(posedge clk); #1;
    chk({tag, "_idle"}, bus.m_axis_tvalid, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    bus.rx_data = '0;
    bus.rx_keep = '0;
    bus.rx_valid = 1'b0;
    bus.rx_last = 1'b0;
    bus.rx_err = 1'b0;
    bus.m_axis_trdy = 1'b0;
    #12;
    chk("rst_tvalid", bus.m_axis_tvalid, 0);
    chk("rst_tlast", bus.m_axis_tlast, 0);
    chk("rst_tuser", bus.m_axis_tuser, 0);
    chk("rst_tdata", bus.m_axis_tdata, 0);
    chk("rst_tkeep", bus.m_axis_tkeep, 0);
    chk("rst_ovf", bus.rx_overflow, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.m_axis_trdy = 1'b1;
    beat(32'h11111111, 4'hF, 1'b0, 1'b0, 1'b1);
    chk("lat_b1", bus.m_axis_tvalid, 1);
    chk("lat_d1", bus.m_axis_tdata, 32'h11111111);
    beat(32'h22222222, 4'hF, 1'b0, 1'b0, 1'b1);
    chk("lat_d2", bus.m_axis_tdata, 32'h22222222);
    beat(32'h00003333, 4'h3, 1'b1, 1'b0, 1'b1);
    chk("lat_d3", bus.m_axis_tdata, 32'h00003333);
    drain("t1_drain");
    base = ovf_cnt;
    bus.m_axis_trdy = 1'b0;
    for (int i = 0; i < 4; i++) beat(32'hA0A0_0000 + i, 4'hF, i == 3, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", bus.m_axis_tvalid, 1);
      chk("bp_data", bus.m_axis_tdata, q[0].d);
    end
    drain("bp_drain");
    chk("bp_ovf", ovf_cnt - base, 0);
    beat(32'hE0E0E0E0, 4'hF, 1'b0, 1'b1, 1'b1);
    beat(32'hE1E1E1E1, 4'hF, 1'b1, 1'b1, 1'b1);
    drain("err_drain");
    base = ovf_cnt;
    bus.m_axis_trdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      beat(32'h100 + i, 4'hF, i == 19, 1'b0, i < 16);
      chk("of_pulse", bus.rx_overflow, i == 16);
    end
    q.push_back('{d: 32'h0, k: 4'h1, l: 1'b1, u: 1'b1});
    drain("of_drain");
    chk("of_cnt", ovf_cnt - base, 1);
    beat(32'h55555555, 4'hF, 1'b0, 1'b0, 1'b1);
    beat(32'h66666666, 4'h7, 1'b1, 1'b0, 1'b1);
    drain("of_next");
    base = ovf_cnt;
    bus.m_axis_trdy = 1'b0;
    for (int i = 0; i < 16; i++) beat(32'h200 + i, 4'hF, i == 15, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      beat(32'h300 + i, 4'hF, i == 2, 1'b0, 1'b0);
      chk("fs_pulse", bus.rx_overflow, i == 0);
    end
    drain("fs_drain");
    chk("fs_cnt", ovf_cnt - base, 1);
    bus.m_axis_trdy = 1'b0;
    for (int i = 0; i < 5; i++) beat(32'h400 + i, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_valid", bus.m_axis_tvalid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", bus.m_axis_tvalid, 0);
    chk("async_rst_data", bus.m_axis_tdata, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.m_axis_trdy = 1'b1;
    beat(32'h77777777, 4'hF, 1'b0, 1'b0, 1'b1);
    beat(32'h88888888, 4'h1, 1'b1, 1'b1, 1'b1);
    drain("rst_next");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
